alu_mult_sequencer: RTL

Multi-cycle shift-add multiplier controller that borrows the shared ALU adder to compute the low DATA_WIDTH bits of a×b. It sits beside the execute stage and accepts one request at a time over a valid/ready handshake. While busy it drives the ALU operand and funct inputs and returns the product over a valid/ready response channel. The low word is identical for signed and unsigned operands, so one sequencer serves MUL.

---
 rtl/alu_mult_sequencer_pkg.sv | 15 +
 rtl/alu_mult_sequencer_if.sv | 29 ++
 rtl/alu_mult_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_mult_sequencer_pkg.sv
// Shared widths, ALU function code and sequencer state encoding for the shift-add multiplier.
package alu_mult_sequencer_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int FUNCT_WIDTH = 4;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD = 4'b0000;

    typedef enum logic [1:0] {
        MSEQ_IDLE = 2'd0,
        MSEQ_BUSY = 2'd1,
        MSEQ_DONE = 2'd2
    } mseq_state_e;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// Request/response handshake plus borrowed-ALU signals between the sequencer and its parent.
interface alu_mult_sequencer_if
    import alu_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);
    logic                   req_valid;
    logic                   req_ready;
    logic [WIDTH-1:0]       req_a;
    logic [WIDTH-1:0]       req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WIDTH-1:0]       resp_product;
    logic [WIDTH-1:0]       alu_din1;
    logic [WIDTH-1:0]       alu_din2;
    logic [FUNCT_WIDTH-1:0] alu_funct;
    logic [WIDTH-1:0]       alu_dout;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, alu_dout,
        output req_ready, resp_valid, resp_product, alu_din1, alu_din2, alu_funct, busy
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, alu_dout,
        input  req_ready, resp_valid, resp_product, alu_din1, alu_din2, alu_funct, busy
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Shift-add multiplier controller producing the low WIDTH bits of a*b through the shared ALU adder.
// Optional ALU_MULT_SEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
//
// state     | meaning
// IDLE      | ready for a request
// BUSY      | one add/shift iteration per cycle
// DONE      | product presented, waiting for resp_ready
module alu_mult_sequencer
    import alu_mult_sequencer_pkg::*;
#(
    parameter int WIDTH     = DATA_WIDTH,
    parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_mult_sequencer_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WIDTH - 1);

    mseq_state_e          state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 req_ready;
    logic                 resp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MSEQ_IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            MSEQ_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    acc_d   = '0;
                    m_d     = bus.req_a;
                    q_d     = bus.req_b;
                    cnt_d   = '0;
                    state_d = MSEQ_BUSY;
                end
            end
            MSEQ_BUSY: begin
`ifdef ALU_MULT_SEQ_EARLY_EXIT_EN
                if (q_q == '0) begin
                    state_d = MSEQ_DONE;
                end else begin
                    if (q_q[0]) acc_d = bus.alu_dout;
                    m_d   = m_q << 1;
                    q_d   = q_q >> 1;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST_CNT) state_d = MSEQ_DONE;
                end
`else
                if (q_q[0]) acc_d = bus.alu_dout;
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == LAST_CNT) state_d = MSEQ_DONE;
`endif
            end
            MSEQ_DONE: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) state_d = MSEQ_IDLE;
            end
            default: state_d = MSEQ_IDLE;
        endcase
    end

    // The ALU operands are driven in every state; the parent muxes them in on busy.
    assign bus.alu_din1     = acc_q;
    assign bus.alu_din2     = m_q;
    assign bus.alu_funct    = FUNCT_ADD;
    assign bus.req_ready    = req_ready;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_product = acc_q;
    assign bus.busy         = (state_q != MSEQ_IDLE);

endmodule
